pwm_mc_dt: RTL and testbench
============================

# pwm_mc_dt

Multi-channel, centre-aligned complementary PWM generator with per-edge dead-time insertion, saturating dead-zone offset and latched fault shutdown. All CH channels share one triangular carrier. Each channel drives a high-side/low-side pair. The block sits between the current/voltage regulators (signed 16-bit duty words) and the gate-driver pins of a half-bridge or multi-phase inverter.

## Interface
- CH, 3: number of channels.
- K, 14: carrier resolution in bits, 2..16.
- DT_W, 8: width of the dead-time word.
- DEADZONE, 0: magnitude added away from zero to each duty word before saturation.

- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- val_in  in  16*CH  signed duty per channel; channel i at [16*i+15:16*i]
- dt  in  DT_W  dead time in clk cycles, shared by all channels
- en  in  1  output enable; 0 forces all outputs low
- fault  in  1  synchronous fault request, level, active-high
- fault_clr  in  1  clears latched fault
- h_out  out  CH  high-side gate, registered
- l_out  out  CH  low-side gate, registered
- fault_st  out  1  latched fault status
- pwm_ready  out  1  high in carrier-extreme cycles, when the shadow load happens

## Operation
- Input stage: val_in is registered every cycle into val_s[i].
- Dead-zone offset: sign-extend val_s to 17 bits. Negative values get −DEADZONE; non-negative values get +DEADZONE.
- Saturation: results above 0x7FFF clamp to 0x7FFF; results below 0x8000 (signed) clamp to 0x8000.
- Duty conversion: duty[i] = sat[15:16−K] + 2^(K−1), mod 2^K, which maps the signed range to 0..2^K−1.
- Carrier: a (K+1)-bit down counter {dir,cnt} free-runs, with period 2^(K+1).
  - pwm_c = dir ? ~cnt : cnt, a triangle sweeping 0..2^K−1 and back.
  - Valley (pwm_c=0) occurs when dir=0 and cnt=0; peak occurs when dir=1 and cnt=0.
- Shadow load: when cnt==0 (twice per period), val[i] <= duty[i]. At any other time val holds its value, so updates are glitch-free.
- Raw compare: raw[i] = (val[i] > pwm_c).
- Dead-time FSM, per channel, states:
  - IDLE: both outputs 0. Entered from reset, from fault, or when en=0. Once enabled and no fault is present, the channel loads the dead-time counter with dt and goes to DEAD.
  - DEAD: both outputs 0. The counter decrements each cycle. When it reaches 0, the channel goes to ON with target = current raw.
  - ON: h = target, l = ~target. A change of raw loads dt and goes to DEAD; if dt=0 the channel goes straight to ON with the new target.
  - A raw change while in DEAD reloads the counter with dt; the target follows the latest raw.
- h and l are never both 1, in any state or cycle.
- Fault (PWM_MC_FAULT_EN compiled in):
  - fault=1 sets fault_st; all channels go to IDLE at the next edge.
  - fault_clr with fault=0 clears fault_st.
  - A simultaneous fault=1 and fault_clr=1 keeps fault_st set.
  - Fault has priority over en.
- pwm_ready = (cnt==0), combinational from the counter register.

## Timing
- Reset values: h_out=0, l_out=0, fault_st=0, pwm_ready=1. val, val_s and the counter reset to 0; all FSMs reset to IDLE.
- Latency from val_in to val: val_in sampled at edge n appears in val at the first cnt==0 edge after n+1.
- Output latency: raw changes in cycle m.
  - With dt=0: outputs switch at edge m+1.
  - With dt=d: both outputs go low at edge m+1, and the new side goes high at edge m+1+d.
- Effective pulse width: each output is shortened by dt per edge. If dt ≥ the raw pulse width, the pulse is suppressed and both outputs stay low.
- Fault/en response: both outputs are low one edge after fault or en=0 is sampled. On release, outputs resume after dt+1 cycles.
- Reset mid-operation: all outputs drop asynchronously, with no dead-time sequence.

## Configuration
- PWM_MC_FAULT_EN defined: fault latch and fault shutdown as described above.
- PWM_MC_FAULT_EN undefined: fault and fault_clr are ignored, fault_st is tied to 0, and only en forces IDLE.

## Test plan
- Reset and carrier: hold rst=0 → h_out=l_out=0, fault_st=0, pwm_ready=1. After release with K=4, pwm_ready pulses every 16 cycles.
- Mid duty, CH=1, K=4, dt=0, DEADZONE=0, val_in=0x0000 → duty=8. h_out is high 16 of every 32 cycles, centred on the valley; l_out is the exact complement.
- Saturation, DEADZONE=0x100, val_in=0x7F80 → clamps to 0x7FFF, duty=15, so h high 30/32 cycles. val_in=0x8050 → clamps to 0x8000, duty=0, so h never high and l high 32/32.
- Dead time, val_in=0, dt=3 → each period has two 3-cycle windows with h=l=0. h is high 13 and l is high 13 of 32 cycles. Never h=l=1.
- Fault: assert fault while h=1 → h=l=0 at the next edge and fault_st=1. Deassert fault, pulse fault_clr → fault_st=0, and outputs resume dt+1 cycles later.
- Shadow: change val_in from 0x0000 to 0x4000 mid-ramp → the h width is unchanged until the edge after the next pwm_ready. Then duty=12, so h is high 24/32 cycles (minus 2·dt).

Source files
------------

// File: rtl/pwm_mc_dt.sv
// pwm_mc_dt: multi-channel centre-aligned complementary PWM with per-channel
// dead-time insertion, dead-zone offset/saturation and an optional latched
// fault shutdown (compile with `define PWM_MC_FAULT_EN to enable the latch).

// Per-channel dead-time sequencer driving one high/low gate pair.
module pwm_mc_dt_lane #(
  parameter int DT_W = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_raw,
  input  logic            i_force,
  input  logic [DT_W-1:0] i_dt,
  output logic            o_h,
  output logic            o_l
);
  typedef enum logic [1:0] {S_IDLE, S_DEAD, S_ON} state_t;

  state_t          r_state, w_state_nx;
  logic [DT_W-1:0] r_cnt, w_cnt_nx;
  logic            r_tgt, w_tgt_nx;
  logic            r_h, r_l, w_h_nx, w_l_nx;

  // State, counter, target and registered gate outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_tgt   <= 1'b0;
      r_h     <= 1'b0;
      r_l     <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_tgt   <= w_tgt_nx;
      r_h     <= w_h_nx;
      r_l     <= w_l_nx;
    end
  end

  // Next state; gates default low so only ON with a settled target drives one.
  // A side only turns on after raw has been stable for dt+1 sampled edges.
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_tgt_nx   = r_tgt;
    w_h_nx     = 1'b0;
    w_l_nx     = 1'b0;
    if (i_force) begin
      w_state_nx = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_tgt_nx = i_raw;
          w_cnt_nx = i_dt;
          if (i_dt == '0) begin
            w_state_nx = S_ON;
            w_h_nx     = i_raw;
            w_l_nx     = ~i_raw;
          end else begin
            w_state_nx = S_DEAD;
          end
        end
        S_DEAD: begin
          if (i_raw != r_tgt) begin
            // raw moved again: restart the dead window on the new target
            w_tgt_nx = i_raw;
            w_cnt_nx = i_dt;
            if (i_dt == '0) begin
              w_state_nx = S_ON;
              w_h_nx     = i_raw;
              w_l_nx     = ~i_raw;
            end
          end else if (r_cnt <= DT_W'(1)) begin
            w_state_nx = S_ON;
            w_h_nx     = r_tgt;
            w_l_nx     = ~r_tgt;
          end else begin
            w_cnt_nx = r_cnt - DT_W'(1);
          end
        end
        S_ON: begin
          if (i_raw != r_tgt) begin
            w_tgt_nx = i_raw;
            w_cnt_nx = i_dt;
            if (i_dt == '0) begin
              w_h_nx = i_raw;
              w_l_nx = ~i_raw;
            end else begin
              w_state_nx = S_DEAD;
            end
          end else begin
            w_h_nx = r_tgt;
            w_l_nx = ~r_tgt;
          end
        end
        default: w_state_nx = S_IDLE;
      endcase
    end
  end

  assign o_h = r_h;
  assign o_l = r_l;
endmodule

module pwm_mc_dt #(
  parameter int CH       = 3,
  parameter int K        = 14,
  parameter int DT_W     = 8,
  parameter int DEADZONE = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [16*CH-1:0]  val_in,
  input  logic [DT_W-1:0]   dt,
  input  logic              en,
  input  logic              fault,
  input  logic              fault_clr,
  output logic [CH-1:0]     h_out,
  output logic [CH-1:0]     l_out,
  output logic              fault_st,
  output logic              pwm_ready
);
  // 18-bit working width leaves headroom for any 16-bit DEADZONE
  localparam logic signed [17:0] DZ     = 18'(DEADZONE);
  localparam logic signed [17:0] SAT_HI = 18'sh07FFF;
  localparam logic signed [17:0] SAT_LO = -18'sh08000;

  logic [CH-1:0][15:0]  r_val_s;
  logic [CH-1:0][K-1:0] r_val;
  logic [CH-1:0][K-1:0] w_duty;
  logic [CH-1:0]        w_raw;
  logic [K:0]           r_car;     // {dir, cnt}
  logic [K-1:0]         w_pwm_c;
  logic                 w_load;
  logic                 w_force;

  assign w_pwm_c   = r_car[K] ? ~r_car[K-1:0] : r_car[K-1:0];
  assign w_load    = (r_car[K-1:0] == '0);
  assign pwm_ready = w_load;

  // Input capture, free-running carrier and shadow duty load at the extremes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_val_s <= '0;
      r_val   <= '0;
      r_car   <= '0;
    end else begin
      r_val_s <= val_in;
      r_car   <= r_car - (K+1)'(1);
      if (w_load) r_val <= w_duty;
    end
  end

  for (genvar gi = 0; gi < CH; gi++) begin : g_ch
    logic signed [17:0] w_ext, w_off;
    logic [15:0]        w_sat;
    logic               w_unused_lsb;

    // Dead-zone offset away from zero, then clamp to the signed 16-bit range.
    always_comb begin
      w_ext = {{2{r_val_s[gi][15]}}, r_val_s[gi]};
      w_off = w_ext[17] ? (w_ext - DZ) : (w_ext + DZ);
      if (w_off > SAT_HI)      w_sat = 16'h7FFF;
      else if (w_off < SAT_LO) w_sat = 16'h8000;
      else                     w_sat = w_off[15:0];
    end

    // Adding 2^(K-1) to the top K bits is just an MSB flip.
    assign w_duty[gi]   = {~w_sat[15], w_sat[14:16-K]};
    assign w_raw[gi]    = (r_val[gi] > w_pwm_c);
    assign w_unused_lsb = ^w_sat;
  end

`ifdef PWM_MC_FAULT_EN
  logic r_fault_st;

  // Fault latch: set wins over clear when both are requested.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)           r_fault_st <= 1'b0;
    else if (fault)     r_fault_st <= 1'b1;
    else if (fault_clr) r_fault_st <= 1'b0;
  end

  // The live fault input acts on the same edge it sets the latch.
  assign w_force  = ~en | fault | r_fault_st;
  assign fault_st = r_fault_st;
`else
  logic w_unused_fault;

  assign w_unused_fault = fault ^ fault_clr;
  assign w_force        = ~en;
  assign fault_st       = 1'b0;
`endif

  pwm_mc_dt_lane #(.DT_W(DT_W)) u_lane [CH-1:0] (
    .clk     (clk),
    .rst     (rst),
    .i_raw   (w_raw),
    .i_force (w_force),
    .i_dt    (dt),
    .o_h     (h_out),
    .o_l     (l_out)
  );
endmodule

// File: tb/tb_pwm_mc_dt.sv
// Bench for pwm_mc_dt: K=4, two channels, DEADZONE=0x100. A cycle-level model
// built from the carrier triangle, duty mapping and the "dt+1 stable samples"
// rule for each gate predicts every output after every clock edge.
module tb_pwm_mc_dt;
  localparam int CH = 2, K = 4, DT_W = 8, DZ = 256;
  localparam int HALF = 1 << K, P = 1 << (K + 1);
`ifdef PWM_MC_FAULT_EN
  localparam bit FEN = 1'b1;
`else
  localparam bit FEN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic [16*CH-1:0]  val_in;
  logic [DT_W-1:0]   dt;
  logic              en, fault, fault_clr;
  logic [CH-1:0]     h_out, l_out;
  logic              fault_st, pwm_ready;

  always #5 clk = ~clk;

  pwm_mc_dt #(.CH(CH), .K(K), .DT_W(DT_W), .DEADZONE(DZ)) dut (
    .clk(clk), .rst(rst), .val_in(val_in), .dt(dt), .en(en), .fault(fault),
    .fault_clr(fault_clr), .h_out(h_out), .l_out(l_out), .fault_st(fault_st),
    .pwm_ready(pwm_ready)
  );

  int n_cmp = 0, n_bad = 0;

  // ---------------- reference model ----------------
  int            m_n;
  int            m_vin [CH];
  int            m_val [CH];
  int            m_run [CH];
  bit            m_rv  [CH];
  logic          m_fst, m_rdy;
  logic [CH-1:0] m_h, m_l;

  // triangle: 0 at the valley, rising to 2^K-1, then falling back
  function automatic int carrier_at(int p);
    if (p == 0) return 0;
    if (p <= HALF) return p - 1;
    return P - p;
  endfunction

  function automatic int duty_of(int v);
    int s;
    s = v + ((v < 0) ? -DZ : DZ);
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
    return (s >>> (16 - K)) + (1 << (K - 1));
  endfunction

  task automatic model_reset();
    m_n = 0; m_fst = 1'b0; m_rdy = 1'b1; m_h = '0; m_l = '0;
    for (int i = 0; i < CH; i++) begin
      m_vin[i] = 0; m_val[i] = 0; m_run[i] = 0; m_rv[i] = 1'b0;
    end
  endtask

  task automatic model_edge();
    int p, c;
    bit frc, raw;
    p = m_n % P;
    c = carrier_at(p);
    frc = !en || (FEN && (fault || m_fst));
    for (int i = 0; i < CH; i++) begin
      raw = (m_val[i] > c);
      if (frc) m_run[i] = 0;
      else if (m_run[i] > 0 && raw == m_rv[i]) m_run[i]++;
      else begin m_run[i] = 1; m_rv[i] = raw; end
      m_h[i] = !frc && (m_run[i] > int'(dt)) && m_rv[i];
      m_l[i] = !frc && (m_run[i] > int'(dt)) && !m_rv[i];
      if (p % HALF == 0) m_val[i] = duty_of(m_vin[i]);
      m_vin[i] = int'($signed(val_in[16*i +: 16]));
    end
    if (FEN) begin
      if (fault) m_fst = 1'b1;
      else if (fault_clr) m_fst = 1'b0;
    end
    m_n++;
    m_rdy = (m_n % HALF == 0);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    int rc;
    rst = 1'b0; en = 1'b0; dt = '0; fault = 1'b0; fault_clr = 1'b0; val_in = '0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (h_out !== '0) begin n_bad++; $display("FAIL reset_h: got %b want 0", h_out); end
    n_cmp++; if (l_out !== '0) begin n_bad++; $display("FAIL reset_l: got %b want 0", l_out); end
    n_cmp++; if (fault_st !== 1'b0) begin n_bad++; $display("FAIL reset_fault_st: got %b want 0", fault_st); end
    n_cmp++; if (pwm_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", pwm_ready); end
    model_reset();
    @(negedge clk) rst = 1'b1;
    rc = 0;
    for (int i = 0; i < 3 * HALF; i++) begin
      step();
      rc += int'(pwm_ready);
      n_cmp++;
      if ({h_out, l_out, fault_st, pwm_ready} !== {m_h, m_l, m_fst, m_rdy}) begin
        n_bad++; $display("FAIL carrier n=%0d: got %b want %b", m_n, {h_out, l_out, fault_st, pwm_ready}, {m_h, m_l, m_fst, m_rdy});
      end
    end
    n_cmp++; if (rc !== 3) begin n_bad++; $display("FAIL ready_pulses: got %0d want 3", rc); end
  endtask

  task automatic test_mid_duty();
    int hc, lc;
    val_in = '0; dt = '0; en = 1'b1;
    hc = 0; lc = 0;
    for (int i = 0; i < 2 * P + P; i++) begin
      step();
      n_cmp++;
      if ({h_out, l_out, fault_st, pwm_ready} !== {m_h, m_l, m_fst, m_rdy}) begin
        n_bad++; $display("FAIL mid_duty n=%0d: got %b want %b", m_n, {h_out, l_out, fault_st, pwm_ready}, {m_h, m_l, m_fst, m_rdy});
      end
      if (i >= 2 * P) begin hc += int'(h_out[0]); lc += int'(l_out[0]); end
    end
    n_cmp++; if (hc !== 16) begin n_bad++; $display("FAIL mid_h_count: got %0d want 16", hc); end
    n_cmp++; if (lc !== 16) begin n_bad++; $display("FAIL mid_l_count: got %0d want 16", lc); end
  endtask

  task automatic test_saturation();
    int h0, h1, l1;
    val_in = {16'h8050, 16'h7F80};
    h0 = 0; h1 = 0; l1 = 0;
    for (int i = 0; i < 3 * P; i++) begin
      step();
      n_cmp++;
      if ({h_out, l_out, fault_st, pwm_ready} !== {m_h, m_l, m_fst, m_rdy}) begin
        n_bad++; $display("FAIL saturation n=%0d: got %b want %b", m_n, {h_out, l_out, fault_st, pwm_ready}, {m_h, m_l, m_fst, m_rdy});
      end
      if (i >= 2 * P) begin h0 += int'(h_out[0]); h1 += int'(h_out[1]); l1 += int'(l_out[1]); end
    end
    n_cmp++; if (h0 !== 30) begin n_bad++; $display("FAIL sat_pos_h: got %0d want 30", h0); end
    n_cmp++; if (h1 !== 0) begin n_bad++; $display("FAIL sat_neg_h: got %0d want 0", h1); end
    n_cmp++; if (l1 !== 32) begin n_bad++; $display("FAIL sat_neg_l: got %0d want 32", l1); end
  endtask

  task automatic test_dead_time();
    int hc, lc, zc, both;
    en = 1'b0; dt = 8'd3; val_in = '0;
    step(); step();
    en = 1'b1;
    hc = 0; lc = 0; zc = 0; both = 0;
    for (int i = 0; i < 3 * P; i++) begin
      step();
      n_cmp++;
      if ({h_out, l_out, fault_st, pwm_ready} !== {m_h, m_l, m_fst, m_rdy}) begin
        n_bad++; $display("FAIL dead_time n=%0d: got %b want %b", m_n, {h_out, l_out, fault_st, pwm_ready}, {m_h, m_l, m_fst, m_rdy});
      end
      both += int'(|(h_out & l_out));
      if (i >= 2 * P) begin
        hc += int'(h_out[0]); lc += int'(l_out[0]); zc += int'(!h_out[0] && !l_out[0]);
      end
    end
    n_cmp++; if (hc !== 13) begin n_bad++; $display("FAIL dt_h_count: got %0d want 13", hc); end
    n_cmp++; if (lc !== 13) begin n_bad++; $display("FAIL dt_l_count: got %0d want 13", lc); end
    n_cmp++; if (zc !== 6) begin n_bad++; $display("FAIL dt_dead_count: got %0d want 6", zc); end
    n_cmp++; if (both !== 0) begin n_bad++; $display("FAIL dt_overlap: got %0d want 0", both); end
  endtask

  task automatic test_fault();
    bit found;
    found = 1'b0;
    for (int i = 0; i < 2 * P && !found; i++) begin
      step();
      if (h_out[0]) found = 1'b1;
    end
    n_cmp++; if (!found) begin n_bad++; $display("FAIL fault_wait_h: got 0 want 1 within %0d cycles", 2 * P); end
    fault = 1'b1;
    step();
    n_cmp++;
    if ({h_out, l_out, fault_st} !== {m_h, m_l, m_fst}) begin
      n_bad++; $display("FAIL fault_assert: got %b want %b", {h_out, l_out, fault_st}, {m_h, m_l, m_fst});
    end
    fault = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++;
      if ({h_out, l_out, fault_st} !== {m_h, m_l, m_fst}) begin
        n_bad++; $display("FAIL fault_hold: got %b want %b", {h_out, l_out, fault_st}, {m_h, m_l, m_fst});
      end
    end
    fault = 1'b1; fault_clr = 1'b1;
    step();
    n_cmp++;
    if ({h_out, l_out, fault_st} !== {m_h, m_l, m_fst}) begin
      n_bad++; $display("FAIL fault_and_clr: got %b want %b", {h_out, l_out, fault_st}, {m_h, m_l, m_fst});
    end
    fault = 1'b0;
    step();
    n_cmp++;
    if ({h_out, l_out, fault_st} !== {m_h, m_l, m_fst}) begin
      n_bad++; $display("FAIL fault_clear: got %b want %b", {h_out, l_out, fault_st}, {m_h, m_l, m_fst});
    end
    fault_clr = 1'b0;
    for (int i = 0; i < int'(dt) + 2 * P; i++) begin
      step();
      n_cmp++;
      if ({h_out, l_out, fault_st, pwm_ready} !== {m_h, m_l, m_fst, m_rdy}) begin
        n_bad++; $display("FAIL fault_resume n=%0d: got %b want %b", m_n, {h_out, l_out, fault_st, pwm_ready}, {m_h, m_l, m_fst, m_rdy});
      end
    end
  endtask

  task automatic test_shadow();
    int hc;
    bit aligned;
    en = 1'b0; dt = '0; val_in = '0;
    step(); step();
    en = 1'b1;
    aligned = 1'b0;
    for (int i = 0; i < 2 * P + HALF && !aligned; i++) begin
      step();
      n_cmp++;
      if ({h_out, l_out, fault_st, pwm_ready} !== {m_h, m_l, m_fst, m_rdy}) begin
        n_bad++; $display("FAIL shadow_pre n=%0d: got %b want %b", m_n, {h_out, l_out, fault_st, pwm_ready}, {m_h, m_l, m_fst, m_rdy});
      end
      if (i >= 2 * P && (m_n % HALF) == 5) aligned = 1'b1;
    end
    val_in = {16'h0000, 16'h4000};
    hc = 0;
    for (int i = 0; i < 3 * P; i++) begin
      step();
      n_cmp++;
      if ({h_out, l_out, fault_st, pwm_ready} !== {m_h, m_l, m_fst, m_rdy}) begin
        n_bad++; $display("FAIL shadow n=%0d: got %b want %b", m_n, {h_out, l_out, fault_st, pwm_ready}, {m_h, m_l, m_fst, m_rdy});
      end
      if (i >= 2 * P) hc += int'(h_out[0]);
    end
    n_cmp++; if (hc !== 24) begin n_bad++; $display("FAIL shadow_h_count: got %0d want 24", hc); end
  endtask

  task automatic test_random();
    int both;
    both = 0;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 6) == 0) val_in[15:0] = 16'($urandom);
      if ($urandom_range(0, 6) == 0) val_in[31:16] = 16'($urandom);
      if ($urandom_range(0, 40) == 0) begin
        en = 1'b0; dt = 8'($urandom_range(0, 5));
      end else if (!en && $urandom_range(0, 3) == 0) begin
        en = 1'b1;
      end
      fault     = ($urandom_range(0, 80) == 0);
      fault_clr = ($urandom_range(0, 10) == 0);
      step();
      both += int'(|(h_out & l_out));
      n_cmp++;
      if ({h_out, l_out, fault_st, pwm_ready} !== {m_h, m_l, m_fst, m_rdy}) begin
        n_bad++; $display("FAIL random n=%0d: got %b want %b", m_n, {h_out, l_out, fault_st, pwm_ready}, {m_h, m_l, m_fst, m_rdy});
      end
    end
    n_cmp++; if (both !== 0) begin n_bad++; $display("FAIL random_overlap: got %0d want 0", both); end
    fault = 1'b0; fault_clr = 1'b0;
  endtask

  task automatic test_reset_mid();
    fault = 1'b0; fault_clr = 1'b1; en = 1'b0; dt = '0; val_in = {16'h1000, 16'hE000};
    step();
    fault_clr = 1'b0; en = 1'b1;
    repeat (2 * P) step();
    n_cmp++;
    if ((h_out ^ l_out) !== '1) begin n_bad++; $display("FAIL pre_reset_active: got %b want 11", h_out ^ l_out); end
    #2 rst = 1'b0;
    #1;
    n_cmp++;
    if ({h_out, l_out, fault_st, pwm_ready} !== {4'b0000, 1'b0, 1'b1}) begin
      n_bad++; $display("FAIL reset_async: got %b want 000001", {h_out, l_out, fault_st, pwm_ready});
    end
    model_reset();
    @(negedge clk) rst = 1'b1;
    for (int i = 0; i < P; i++) begin
      step();
      n_cmp++;
      if ({h_out, l_out, fault_st, pwm_ready} !== {m_h, m_l, m_fst, m_rdy}) begin
        n_bad++; $display("FAIL after_reset n=%0d: got %b want %b", m_n, {h_out, l_out, fault_st, pwm_ready}, {m_h, m_l, m_fst, m_rdy});
      end
    end
  endtask

  initial begin
    test_reset();
    test_mid_duty();
    test_saturation();
    test_dead_time();
    test_fault();
    test_shadow();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
